cfg_loader: RTL and testbench

Configuration loader for the tile array. It accepts a byte-wide configuration stream through a valid/ready handshake and packs each run of bytes into one 77-bit tile frame. It then writes each frame to its tile with a one-cycle one-hot write-enable pulse. It sits between the external programming port and the array, sequencing tiles 0..NUM_TILES-1 in order.

---
 rtl/cfg_loader.sv | 132 +++++++++++++
 tb/tb_cfg_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// Configuration loader: packs a byte stream into FRAME_W-bit tile frames and writes them to tiles 0..NUM_TILES-1 in order.
// Optional end-of-load checksum beat is enabled by defining CFG_LOADER_CHECKSUM_EN.
module cfg_loader #(
  parameter int NUM_TILES = 4,
  parameter int FRAME_W   = 77,
  parameter int IN_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FRAME_W-1:0]   tile_bits,
  output logic [NUM_TILES-1:0] tile_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BYTES_PER_FRAME = (FRAME_W + IN_W - 1) / IN_W;
  localparam int BYTE_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_FRAME - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

`ifdef CFG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  state_t            state, state_next;
  logic [BYTE_W-1:0] byte_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic              beat_ok;

  assign beat_ok = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Outputs decode the registered state, so a WRITE pulse still fires in the cycle an abort arrives.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    tile_wr_en = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (abort)                                 state_next = IDLE;
        else if (in_valid && byte_cnt == BYTE_LAST) state_next = WRITE;
      end
      WRITE: begin
        tile_wr_en = NUM_TILES'(1) << tile_cnt;
        if (abort)                       state_next = IDLE;
`ifdef CFG_LOADER_CHECKSUM_EN
        else if (tile_cnt == TILE_LAST) state_next = CHECK;
`else
        else if (tile_cnt == TILE_LAST) state_next = DONE;
`endif
        else                             state_next = LOAD;
      end
`ifdef CFG_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (abort)         state_next = IDLE;
        else if (in_valid) state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat k lands in frame bits [k*IN_W +: IN_W]; bits of the last beat beyond FRAME_W have no home and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      tile_cnt  <= '0;
      tile_bits <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          tile_cnt <= '0;
        end
        LOAD: if (beat_ok) begin
          for (int b = 0; b < FRAME_W; b++)
            if (byte_cnt == BYTE_W'(b / IN_W)) tile_bits[b] <= in_data[b % IN_W];
          byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + 1'b1;
        end
        WRITE: if (tile_cnt != TILE_LAST) tile_cnt <= tile_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [IN_W-1:0] csum;
  logic            err_q;

  // Running XOR covers full beats including padding; err is sticky until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (state == LOAD && beat_ok) begin
      csum <= csum ^ in_data;
    end else if (state == CHECK && beat_ok) begin
      err_q <= (in_data != csum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboarded bench for cfg_loader: randomized loads, gaps, padding, abort, reset, and the optional checksum.
module tb_cfg_loader;

  localparam int NT  = 4;
  localparam int FW  = 77;
  localparam int IW  = 8;
  localparam int BPF = 10;

  logic          clk, rst, start, abort, in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready, busy, done, err;
  logic [FW-1:0] tile_bits;
  logic [NT-1:0] tile_wr_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int tile; logic [FW-1:0] frame; int cyc; } wr_exp_t;
  typedef struct { logic err; int cyc; } done_exp_t;
  wr_exp_t   wq[$];
  done_exp_t dq[$];

  cfg_loader #(.NUM_TILES(NT), .FRAME_W(FW), .IN_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tile_bits(tile_bits), .tile_wr_en(tile_wr_en),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and done pulse must match the next queued expectation.
  initial begin
    wr_exp_t   e;
    done_exp_t d;
    forever begin
      @(posedge clk);
      #1;
      if (tile_wr_en != '0) begin
        checkOutput("wr_onehot", $countones(tile_wr_en), 1);
        checkOutput("ready_during_wr", in_ready, 0);
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_wr actual=%0h required=none", tile_wr_en);
        end else begin
          e = wq.pop_front();
          checkOutput("wr_en", tile_wr_en, NT'(1) << e.tile);
          checkOutput("tile_bits", tile_bits, e.frame);
          checkOutput("wr_latency", cyc, e.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          d = dq.pop_front();
          checkOutput("done_err", err, d.err);
          checkOutput("done_latency", cyc, d.cyc);
        end
      end
    end
  end

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_cleared_on_start", err, 0);
  endtask

  // gap: 0 always valid, 1 toggling, 2 random. stop_kind: 0 none, 1 abort, 2 reset at (stop_tile, stop_beat).
  task automatic applyStimulus(input int gap, input bit incr, input bit pad, input int stop_tile,
                               input int stop_beat, input int stop_kind, input int start_at, input bit corrupt);
    logic [IW-1:0] bytes[NT][BPF];
    logic [IW-1:0] csum;
    logic [79:0]   wide;
    bit            tog;
    int            gbeat;
    csum = '0; tog = 1'b0; gbeat = 0;
    for (int t = 0; t < NT; t++)
      for (int k = 0; k < BPF; k++) begin
        bytes[t][k] = incr ? IW'(t * BPF + k + 1) : IW'($urandom_range(0, 255));
        if (pad && k == BPF - 1) bytes[t][k] = 8'hFF;
      end
    doStart();
    for (int t = 0; t < NT; t++) begin
      for (int k = 0; k < BPF; k++) begin
        int tries;
        bit got;
        tries = 0; got = 1'b0;
        while (!got) begin
          @(negedge clk);
          start = 1'b0;
          if (stop_kind != 0 && t == stop_tile && k == stop_beat) begin
            in_valid = 1'b0;
            if (stop_kind == 1) abort = 1'b1; else rst = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_ready", in_ready, 0);
            checkOutput("stop_done", done, 0);
            checkOutput("stop_wr_en", tile_wr_en, 0);
            if (stop_kind == 2) begin
              checkOutput("rst_tile_bits", tile_bits, 0);
              checkOutput("rst_err", err, 0);
            end
            rst = 1'b0;
            return;
          end
          if (tries == 0 && k == 0 && t > 0) checkOutput("ready_low_in_write", in_ready, 0);
          case (gap)
            0:       in_valid = 1'b1;
            1:       begin tog = ~tog; in_valid = tog; end
            default: in_valid = 1'($urandom_range(0, 1));
          endcase
          in_data = in_valid ? bytes[t][k] : IW'($urandom_range(0, 255));
          if (gbeat == start_at && tries == 0) start = 1'b1;
          got = in_valid && in_ready;
          tries++;
          if (tries > 60) begin
            checks++; errors++;
            $display("[TB] FAIL beat_timeout actual=%0d required<=60", tries);
            in_valid = 1'b0;
            return;
          end
        end
        if (gap == 0 && k == 0 && t > 0) checkOutput("next_frame_accept_t2", tries, 2);
        gbeat++;
        csum ^= bytes[t][k];
        if (k == BPF - 1) begin
          wide = '0;
          for (int j = 0; j < BPF; j++) wide = wide | (80'(bytes[t][j]) << (IW * j));
          wq.push_back('{tile: t, frame: wide[FW-1:0], cyc: cyc + 1});
`ifndef CFG_LOADER_CHECKSUM_EN
          if (t == NT - 1) dq.push_back('{err: 1'b0, cyc: cyc + 2});
`endif
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
    begin
      int tries;
      bit got;
      tries = 0; got = 1'b0;
      while (!got && tries < 20) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data = csum ^ IW'(corrupt);
        got = in_ready;
        tries++;
      end
      if (got) dq.push_back('{err: corrupt, cyc: cyc + 1});
      else begin
        checks++; errors++;
        $display("[TB] FAIL csum_timeout actual=%0d required<20", tries);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
`endif
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("busy_drops", busy, 0);
`ifdef CFG_LOADER_CHECKSUM_EN
    checkOutput("err_holds", err, corrupt);
`else
    checkOutput("err_tied_low", err, 0);
`endif
  endtask

  task automatic drainCheck();
    repeat (3) @(negedge clk);
    checkOutput("wr_queue_empty", wq.size(), 0);
    checkOutput("done_queue_empty", dq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wr_en", tile_wr_en, 0);
    checkOutput("reset_tile_bits", tile_bits, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;

    $display("[TB] basic incrementing load");
    applyStimulus(0, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    drainCheck();
    $display("[TB] toggling valid");
    applyStimulus(1, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    drainCheck();
    $display("[TB] padding beat 0xFF");
    applyStimulus(2, 1'b0, 1'b1, -1, -1, 0, -1, 1'b0);
    checkOutput("pad_top_bits", tile_bits[FW-1:72], 5'h1F);
    drainCheck();
    $display("[TB] abort after 3 beats of tile 1");
    applyStimulus(0, 1'b0, 1'b0, 1, 3, 1, -1, 1'b0);
    drainCheck();
    applyStimulus(2, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
    drainCheck();
    $display("[TB] reset during tile 1, start pulse mid-load");
    applyStimulus(0, 1'b0, 1'b0, 1, 3, 2, 5, 1'b0);
    drainCheck();
    applyStimulus(1, 1'b0, 1'b0, -1, -1, 0, 4, 1'b0);
    drainCheck();
    $display("[TB] checksum corrupt then clean");
    applyStimulus(2, 1'b0, 1'b0, -1, -1, 0, -1, 1'b1);
    repeat (4) @(negedge clk);
`ifdef CFG_LOADER_CHECKSUM_EN
    checkOutput("err_still_held", err, 1);
`endif
    drainCheck();
    applyStimulus(0, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
    drainCheck();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(2, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
      drainCheck();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
